// File: rtl/shift_register.sv
// Universal shift register: parallel load, shift left, shift right, hold.
// Define SHIFT_REGISTER_SHIFT_OUT_EN to add the msb_out/lsb_out serial taps.
module shift_register #(
  parameter int width = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_enable,
  input  logic [width-1:0] data_in,
  input  logic             left_shift_enable,
  input  logic             left_shift_value,
  input  logic             right_shift_enable,
  input  logic             right_shift_value,
`ifdef SHIFT_REGISTER_SHIFT_OUT_EN
  output logic             msb_out,
  output logic             lsb_out,
`endif
  output logic [width-1:0] data_out
);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LEFT  = 2'b11;

  logic [1:0]       sel;
  logic             stage_enable;
  logic [width-1:0] data_reg;
  logic [width-1:0] data_next;

  // The select encoding alone realises load > left > right priority.
  assign sel[1]       = ~load_enable & (left_shift_enable | right_shift_enable);
  assign sel[0]       = load_enable | left_shift_enable;
  assign stage_enable = load_enable | left_shift_enable | right_shift_enable;

  genvar gi;
  generate
    for (gi = 0; gi < width; gi++) begin : g_stage
      logic left_src;
      logic right_src;

      if (gi == 0) begin : g_lsb
        assign left_src = left_shift_value;
      end else begin : g_left
        assign left_src = data_reg[gi-1];
      end

      if (gi == width - 1) begin : g_msb
        assign right_src = right_shift_value;
      end else begin : g_right
        assign right_src = data_reg[gi+1];
      end

      always_comb begin
        data_next[gi] = data_reg[gi];
        case (sel)
          SEL_HOLD:  data_next[gi] = data_reg[gi];
          SEL_LOAD:  data_next[gi] = data_in[gi];
          SEL_RIGHT: data_next[gi] = right_src;
          SEL_LEFT:  data_next[gi] = left_src;
          default:   data_next[gi] = data_reg[gi];
        endcase
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          data_reg[gi] <= 1'b0;
        end else if (stage_enable) begin
          data_reg[gi] <= data_next[gi];
        end
      end
    end
  endgenerate

  assign data_out = data_reg;

`ifdef SHIFT_REGISTER_SHIFT_OUT_EN
  assign msb_out = data_reg[width-1];
  assign lsb_out = data_reg[0];
`endif

endmodule

// File: tb/tb_shift_register.sv
// Directed and random checks of shift_register (width 8) using an
// expected-value queue filled at drive time and drained after each edge.
module tb_shift_register;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         load_enable;
  logic [W-1:0] data_in;
  logic         left_shift_enable;
  logic         left_shift_value;
  logic         right_shift_enable;
  logic         right_shift_value;
  logic [W-1:0] data_out;
`ifdef SHIFT_REGISTER_SHIFT_OUT_EN
  logic         msb_out;
  logic         lsb_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;

  shift_register #(.width(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .load_enable        (load_enable),
    .data_in            (data_in),
    .left_shift_enable  (left_shift_enable),
    .left_shift_value   (left_shift_value),
    .right_shift_enable (right_shift_enable),
    .right_shift_value  (right_shift_value),
`ifdef SHIFT_REGISTER_SHIFT_OUT_EN
    .msb_out            (msb_out),
    .lsb_out            (lsb_out),
`endif
    .data_out           (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_next(
    input logic [W-1:0] cur, input logic rst, input logic ld, input logic [W-1:0] din,
    input logic le, input logic lv, input logic re, input logic rv);
    if (!rst)    return '0;
    else if (ld) return din;
    else if (le) return {cur[W-2:0], lv};
    else if (re) return {rv, cur[W-1:1]};
    else         return cur;
  endfunction

  // Drive one cycle of inputs, push the expected result, clock, then compare.
  task automatic step(input string tag, input logic rst, input logic ld,
                      input logic [W-1:0] din, input logic le, input logic lv,
                      input logic re, input logic rv, input logic [W-1:0] expected);
    logic [W-1:0] exp_val;
    reset = rst; load_enable = ld; data_in = din;
    left_shift_enable = le; left_shift_value = lv;
    right_shift_enable = re; right_shift_value = rv;
    exp_q.push_back(expected);
    model = expected;
    @(posedge clk);
    #1;
    exp_val = exp_q.pop_front();
    tests_run++;
    assert (data_out === exp_val) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, data_out, exp_val);
    end
    $display("[TB] %s rst=%b ld=%b din=%b l=%b/%b r=%b/%b -> %b", tag, rst, ld, din,
             le, lv, re, rv, data_out);
  endtask

  initial begin
    reset = 1'b1; load_enable = 1'b0; data_in = '0;
    left_shift_enable = 1'b0; left_shift_value = 1'b0;
    right_shift_enable = 1'b0; right_shift_value = 1'b0;
    model = '0;
    @(negedge clk);

    step("reset_all_en", 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'b00000000);
    step("load",         1'b1, 1'b1, 8'b10110010, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10110010);
    step("hold1",        1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'b10110010);
    step("hold2",        1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10110010);
    step("hold3",        1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'b10110010);
    step("left_v0",      1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'b01100100);
    step("left_v1",      1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11001001);
    step("right_v1",     1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'b11100100);
    step("right_v0",     1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'b01110010);
    step("prio_load",    1'b1, 1'b1, 8'b00001111, 1'b1, 1'b0, 1'b1, 1'b0, 8'b00001111);
    step("prio_left",    1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'b00011111);
    step("reset_load",   1'b0, 1'b1, 8'b11111111, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000000);
    step("resume_load",  1'b1, 1'b1, 8'b10000001, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10000001);

`ifdef SHIFT_REGISTER_SHIFT_OUT_EN
    tests_run++;
    assert (msb_out === 1'b1) else begin
      tests_failed++;
      $error("FAIL msb_out: observed %b expected 1", msb_out);
    end
    tests_run++;
    assert (lsb_out === 1'b1) else begin
      tests_failed++;
      $error("FAIL lsb_out: observed %b expected 1", lsb_out);
    end
`endif

    // Continuous right shift, one position per edge.
    step("rsh_run1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'b01000000);
    step("rsh_run2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'b10100000);
    step("rsh_run3", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'b11010000);
    // Reset asserted in the middle of a shift sequence.
    step("rst_mid",  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'b00000000);

    for (int i = 0; i < 60; i++) begin
      logic r, ld, le, lv, re, rv;
      logic [W-1:0] din;
      r   = ($urandom_range(0, 15) != 0);
      ld  = ($urandom_range(0, 3) == 0);
      le  = 1'($urandom_range(0, 1));
      lv  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      step("random", r, ld, din, le, lv, re, rv,
           model_next(model, r, ld, din, le, lv, re, rv));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_register.md
SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 SHALL have parameter: width, default 9, register bit count (legal range width >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset (reset == 0 clears on the next rising clk edge).
REQ-004 SHALL have port: load_enable  input  1  parallel load request.
REQ-005 SHALL have port: data_in  input  width  parallel load data.
REQ-006 SHALL have port: left_shift_enable  input  1  shift-left request.
REQ-007 SHALL have port: left_shift_value  input  1  bit inserted at LSB on a left shift.
REQ-008 SHALL have port: right_shift_enable  input  1  shift-right request.
REQ-009 SHALL have port: right_shift_value  input  1  bit inserted at MSB on a right shift (the caller drives the MSB for an arithmetic shift).
REQ-010 SHALL have port: data_out  output  width  current register contents, driven directly from the flip-flops.

Function
REQ-011 SHALL be built as width per-bit stages; each stage is a 4-to-1 mux (hold / load / right / left) feeding a clock-enabled D flip-flop.
REQ-012 SHALL encode the mux select as sel[1] = ~load_enable & (left_shift_enable | right_shift_enable) and sel[0] = load_enable | left_shift_enable.
REQ-013 SHALL use the select codes: 00 hold, 01 load, 10 right shift, 11 left shift.
REQ-014 SHALL apply priority load > left shift > right shift > hold when requests overlap.
REQ-015 SHALL on load set data_out <= data_in at the next edge (latency 1 clock).
REQ-016 SHALL on left shift set bit i <= bit i-1 for i >= 1, and bit 0 <= left_shift_value.
REQ-017 SHALL on right shift set bit i <= bit i+1 for i <= width-2, and bit width-1 <= right_shift_value.
REQ-018 SHALL enable the flip-flops only when load_enable | left_shift_enable | right_shift_enable is 1; otherwise data_out holds its value indefinitely.
REQ-019 SHALL sample the serial input bits on the same edge as the shift, so the value inserted is the one present at that edge.
REQ-020 SHALL shift exactly one position per clock for as long as a shift enable stays high.
REQ-021 SHALL contain no combinational path from any input to data_out.

Reset
REQ-022 SHALL clear data_out to all zeros on a rising clk edge when reset == 0.
REQ-023 SHALL give reset priority over load and both shifts, including when reset is asserted mid-operation.
REQ-024 SHALL have no asynchronous effect from reset; data_out changes only at clk edges.
REQ-025 SHALL resume normal operation from the first edge at which reset == 1.

Configuration
REQ-026 SHALL, when macro SHIFT_REGISTER_SHIFT_OUT_EN is defined, add outputs msb_out (1 bit) = data_out[width-1] and lsb_out (1 bit) = data_out[0], both combinational from the flops.
REQ-027 SHALL, when SHIFT_REGISTER_SHIFT_OUT_EN is undefined, omit msb_out and lsb_out; all other behaviour is identical to the macro-defined build.

Verification (width = 8)
REQ-028 SHALL verify: reset = 0 for one edge with any enables active -> data_out = 00000000.
REQ-029 SHALL verify: load_enable = 1, data_in = 10110010 for one edge -> 10110010; then all enables 0 for several edges -> value held.
REQ-030 SHALL verify: left shift from 10110010 with value 0 -> 01100100; next edge with value 1 -> 11001001.
REQ-031 SHALL verify: right shift from 11001001 with value 1 -> 11100100; next edge with value 0 -> 01110010.
REQ-032 SHALL verify: with register at 01110010, all three enables = 1 and data_in = 00001111 -> 00001111 (load wins); both shift enables = 1, left value 1 -> 00011111 (left wins).
REQ-033 SHALL verify: reset = 0 coincident with load_enable = 1, data_in = 11111111 -> 00000000; with SHIFT_REGISTER_SHIFT_OUT_EN defined and register at 10000001 -> msb_out = 1, lsb_out = 1.
